// File: rtl/mips_multicycle_cpu.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencer sharing one
// request/ready memory port, with halt state, sticky illegal flag and retire pulse.
module mips_multicycle_cpu #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] mdr_q, mdr_d;
    logic        illegal_q, illegal_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] regs_q [32];

    logic        retire_c;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    // Instruction fields and derived addresses, all taken from the latched IR.
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext, pc_plus4, br_target, j_target;
    logic        is_rtype, is_addi, is_lw, is_sw, is_beq, is_j, funct_ok, insn_ok;

    assign opcode    = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign funct     = ir_q[5:0];
    assign imm_sext  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign funct_ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    assign insn_ok  = (is_rtype && funct_ok) || is_addi || is_lw || is_sw || is_beq || is_j;

    // A transfer only completes while our own request is up; stray ready is ignored.
    logic xfer;
    assign xfer = mem_req_q && mem_ready;

    logic [31:0] alu_b, alu_res;

    always_comb begin
        alu_b   = is_rtype ? b_q : imm_sext;
        alu_res = a_q + alu_b;
        if (is_rtype) begin
            case (funct)
                FN_SUB:  alu_res = a_q - b_q;
                FN_AND:  alu_res = a_q & b_q;
                FN_OR:   alu_res = a_q | b_q;
                FN_SLT:  alu_res = {31'b0, ($signed(a_q) < $signed(b_q))};
                default: alu_res = a_q + b_q;
            endcase
        end
    end

    // NOTE: every signal gets its hold/default value before the case so no path
    // leaves one unassigned; that is what keeps this block free of latches.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        illegal_d = illegal_q;
        retire_c  = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = is_rtype ? rd : rt;
        rf_wdata  = is_lw ? mdr_q : alu_out_q;

        case (state_q)
            S_FETCH: begin
                if (xfer) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ir_q == HALT_WORD) begin
                    state_d = S_HALT;
                end else if (!insn_ok) begin
                    illegal_d = 1'b1;
                    retire_c  = 1'b1;
                    pc_d      = pc_plus4;
                    state_d   = S_FETCH;
                end else begin
                    a_d     = regs_q[rs];
                    b_d     = regs_q[rt];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    pc_d     = (a_q == b_q) ? br_target : pc_plus4;
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_j) begin
                    pc_d     = j_target;
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    alu_out_d = alu_res;
                    state_d   = (is_lw || is_sw) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                if (xfer) begin
                    if (is_sw) begin
                        pc_d     = pc_plus4;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                pc_d     = pc_plus4;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Port outputs are registered from the next state so the request and its
    // address are already valid in the first cycle of FETCH or MEM.
    always_comb begin
        mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
        mem_we_d    = (state_d == S_MEM) && is_sw;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_d == S_FETCH) begin
            mem_addr_d = pc_d;
        end else if (state_d == S_MEM) begin
            mem_addr_d  = alu_out_d;
            mem_wdata_d = b_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops sample
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_out_q   <= '0;
            mdr_q       <= '0;
            illegal_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_out_q   <= alu_out_d;
            mdr_q       <= mdr_d;
            illegal_q   <= illegal_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // NOTE: the register file is cleared by reset, which forces it into flops
    // rather than a RAM macro; $0 stays zero because writes to it are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc        = pc_q;
    assign retire    = retire_c;
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;

endmodule
